octant_rom_arbiter: RTL

- Round-robin arbiter that shares the two read ports of the octant ROM between NUM_REQ ray-traversal requesters.
- Each cycle it grants up to two requests: one per ROM port.
- It drives the ROM addresses and read enables, then routes each returned word, one cycle later, to the requester that issued it.
- Addresses outside the ROM are rejected with an error response.

---
 rtl/octant_rom_arbiter_if.sv | 32 +++
 rtl/octant_rom_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/octant_rom_arbiter_if.sv
// Requester and ROM-port bundle for the octant ROM arbiter.
// Handshake: a request transfers in any cycle where req_valid[i] && req_ready[i]; responses are unthrottled strobes.
interface octant_rom_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               resp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0]    resp_data;
  logic [NUM_REQ-1:0]               resp_err;
  logic [ADDRESS_WIDTH-1:0]         rom_addr1;
  logic [ADDRESS_WIDTH-1:0]         rom_addr2;
  logic                             rom_ren1;
  logic                             rom_ren2;
  logic [DATA_WIDTH-1:0]            rom_dout1;
  logic [DATA_WIDTH-1:0]            rom_dout2;

  modport master (
    output req_valid, req_addr, rom_dout1, rom_dout2,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  rom_addr1, rom_addr2, rom_ren1, rom_ren2
  );

  modport slave (
    input  req_valid, req_addr, rom_dout1, rom_dout2,
    output req_ready, resp_valid, resp_data, resp_err,
    output rom_addr1, rom_addr2, rom_ren1, rom_ren2
  );
endinterface

// File: rtl/octant_rom_arbiter.sv
// Round-robin arbiter sharing two ROM read ports among NUM_REQ requesters.
// Grants are combinational; each ROM word is routed back to its owner one cycle later.
module octant_rom_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ROM_DEPTH     = 4306,
  localparam int PTR_W        = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  octant_rom_arbiter_if.slave bus,
  output logic [PTR_W-1:0] rr_ptr_o
);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] g1_idx, g2_idx, last_idx;
  logic [PTR_W:0]   scan;
  logic             g1_vld, g2_vld, g1_oor, g2_oor;
  logic [NUM_REQ-1:0] ready_d;
  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] addr_a;

  logic             s1_vld_q, s2_vld_q, s1_err_q, s2_err_q;
  logic [PTR_W-1:0] s1_own_q, s2_own_q;

  logic [NUM_REQ-1:0]                 resp_valid_d, resp_err_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_d, held_q;

  assign addr_a = bus.req_addr;

  // Scan from rr_ptr with wrap; first valid takes port 1, second takes port 2.
  always_comb begin
    g1_vld  = 1'b0;
    g2_vld  = 1'b0;
    g1_idx  = '0;
    g2_idx  = '0;
    scan    = '0;
    ready_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NUM_REQ)) scan = scan - (PTR_W+1)'(NUM_REQ);
      if (!rst && bus.req_valid[scan[PTR_W-1:0]]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan[PTR_W-1:0];
        end else if (!g2_vld) begin
          g2_vld = 1'b1;
          g2_idx = scan[PTR_W-1:0];
        end
      end
    end
    if (g1_vld) ready_d[g1_idx] = 1'b1;
    if (g2_vld) ready_d[g2_idx] = 1'b1;
  end

  assign g1_oor = g1_vld && (addr_a[g1_idx] >= ADDRESS_WIDTH'(ROM_DEPTH));
  assign g2_oor = g2_vld && (addr_a[g2_idx] >= ADDRESS_WIDTH'(ROM_DEPTH));

  assign bus.req_ready = ready_d;
  assign bus.rom_ren1  = g1_vld && !g1_oor;
  assign bus.rom_ren2  = g2_vld && !g2_oor;
  assign bus.rom_addr1 = bus.rom_ren1 ? addr_a[g1_idx] : '0;
  assign bus.rom_addr2 = bus.rom_ren2 ? addr_a[g2_idx] : '0;

  always_comb begin
    last_idx = g2_vld ? g2_idx : g1_idx;
    rr_ptr_d = rr_ptr_q;
    if (g1_vld) rr_ptr_d = (last_idx == PTR_W'(NUM_REQ-1)) ? '0 : last_idx + 1'b1;
  end

  // Responses come from last cycle's slots; rst suppresses them immediately.
  always_comb begin
    resp_valid_d = '0;
    resp_err_d   = '0;
    data_d       = held_q;
    if (!rst) begin
      if (s1_vld_q) begin
        resp_valid_d[s1_own_q] = 1'b1;
        resp_err_d[s1_own_q]   = s1_err_q;
        data_d[s1_own_q]       = s1_err_q ? '0 : bus.rom_dout1;
      end
      if (s2_vld_q) begin
        resp_valid_d[s2_own_q] = 1'b1;
        resp_err_d[s2_own_q]   = s2_err_q;
        data_d[s2_own_q]       = s2_err_q ? '0 : bus.rom_dout2;
      end
    end
  end

  assign bus.resp_valid = resp_valid_d;
  assign bus.resp_err   = resp_err_d;
  assign bus.resp_data  = data_d;
  assign rr_ptr_o       = rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_err_q <= 1'b0;
      s2_err_q <= 1'b0;
      s1_own_q <= '0;
      s2_own_q <= '0;
      held_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      s1_vld_q <= g1_vld;
      s2_vld_q <= g2_vld;
      s1_err_q <= g1_oor;
      s2_err_q <= g2_oor;
      s1_own_q <= g1_idx;
      s2_own_q <= g2_idx;
      held_q   <= data_d;
    end
  end

endmodule
